// File: rtl/uart_bus_bridge_pkg.sv
// Opcodes, response byte and frame-FSM encoding shared by the UART bus bridge.
package uart_bus_bridge_pkg;

   localparam logic [7:0] OP_WR = 8'h57;
   localparam logic [7:0] OP_RD = 8'h52;
   localparam logic [7:0] ACK   = 8'h4B;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR_H   = 3'd1,
      ST_ADDR_L   = 3'd2,
      ST_DATA_H   = 3'd3,
      ST_DATA_L   = 3'd4,
      ST_BUS_REQ  = 3'd5,
      ST_BUS_XFER = 3'd6,
      ST_RESP     = 3'd7
   } frame_st_e;

   // States that are still collecting command bytes and may be abandoned.
   function automatic logic is_collect(input frame_st_e s);
      return (s == ST_ADDR_H) || (s == ST_ADDR_L) || (s == ST_DATA_H) || (s == ST_DATA_L);
   endfunction

endpackage

// File: rtl/uart_bridge_tx.sv
// 8N1 byte serializer: i_ld starts the start bit next cycle; 10*BAUD_DIV cycles per byte.
// A load is accepted when idle or on the o_done cycle, so consecutive bytes leave no gap.
module uart_bridge_tx #(
   parameter logic [15:0] BAUD_DIV = 16'd434
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_ld,
   input  logic [7:0] i_byte,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_done
);

   logic        r_busy;
   logic [15:0] r_baud;
   logic [3:0]  r_bit;
   logic [7:0]  r_shift;
   logic        r_tx;
   logic        w_last_cyc;

   assign w_last_cyc = (r_baud == BAUD_DIV - 16'd1);
   assign o_done     = r_busy && w_last_cyc && (r_bit == 4'd9);
   assign o_busy     = r_busy;
   assign o_tx       = r_tx;

   // r_bit is the period now on the line: 0 start, 1..8 data, 9 stop.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_busy  <= 1'b0;
         r_baud  <= 16'd0;
         r_bit   <= 4'd0;
         r_shift <= 8'd0;
         r_tx    <= 1'b1;
      end else if (i_ld && (!r_busy || o_done)) begin
         r_busy  <= 1'b1;
         r_baud  <= 16'd0;
         r_bit   <= 4'd0;
         r_shift <= i_byte;
         r_tx    <= 1'b0;
      end else if (r_busy) begin
         if (w_last_cyc) begin
            r_baud <= 16'd0;
            if (r_bit == 4'd9) begin
               r_busy <= 1'b0;
               r_bit  <= 4'd0;
               r_tx   <= 1'b1;
            end else begin
               r_bit <= r_bit + 4'd1;
               r_tx  <= (r_bit == 4'd8) ? 1'b1 : r_shift[r_bit[2:0]];
            end
         end else begin
            r_baud <= r_baud + 16'd1;
         end
      end
   end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command frames ('W' a a d d / 'R' a a) to single 16-bit bus transfers; replies 'K' or read data.
// busReq 1 cycle after last stop sample, busEn 1 cycle after grant; optional UART_BUS_BRIDGE_TIMEOUT_EN.
module uart_bus_bridge
   import uart_bus_bridge_pkg::*;
#(
   parameter logic [15:0] BAUD_DIV    = 16'd434,
   parameter logic [23:0] TIMEOUT_CYC = 24'd500000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        rxIn,
   output logic        txOut,
   output logic        busReq,
   input  logic        busGnt,
   output logic        busEn,
   output logic        busWr,
   output logic [15:0] busAddr,
   inout  wire  [15:0] busData
);

   logic        r_rx_s1, r_rx_s2, r_rx_s3;
   logic        r_rx_busy;
   logic [15:0] r_rx_baud;
   logic [3:0]  r_rx_bit;
   logic [7:0]  r_rx_shift;
   logic        w_rx_start, w_rx_mid, w_rx_vld, w_rx_ferr;

   frame_st_e   r_st, w_st_nxt;
   logic        r_wr, r_resp_lo;
   logic [15:0] r_addr, r_data;
   logic        w_drv_data, w_tx_ld, w_tx_busy, w_tx_done, w_timeout;
   logic [7:0]  w_tx_byte;

   assign w_rx_start = !r_rx_busy && r_rx_s3 && !r_rx_s2;
   assign w_rx_mid   = r_rx_busy && (r_rx_baud == (BAUD_DIV >> 1));
   assign w_rx_vld   = w_rx_mid && (r_rx_bit == 4'd9) && r_rx_s2;
   assign w_rx_ferr  = w_rx_mid && (r_rx_bit == 4'd9) && !r_rx_s2;

   // r_rx_s3 is only the previous synchronised level, used for falling-edge detection.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_s3    <= 1'b1;
         r_rx_busy  <= 1'b0;
         r_rx_baud  <= 16'd0;
         r_rx_bit   <= 4'd0;
         r_rx_shift <= 8'd0;
      end else begin
         r_rx_s1 <= rxIn;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
         if (w_rx_start) begin
            r_rx_busy <= 1'b1;
            r_rx_baud <= 16'd0;
            r_rx_bit  <= 4'd0;
         end else if (r_rx_busy) begin
            if (w_rx_mid && ((r_rx_bit == 4'd0 && r_rx_s2) || r_rx_bit == 4'd9)) begin
               r_rx_busy <= 1'b0;
               r_rx_baud <= 16'd0;
               r_rx_bit  <= 4'd0;
            end else begin
               if (w_rx_mid && r_rx_bit != 4'd0)
                  r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
               if (r_rx_baud == BAUD_DIV - 16'd1) begin
                  r_rx_baud <= 16'd0;
                  r_rx_bit  <= r_rx_bit + 4'd1;
               end else begin
                  r_rx_baud <= r_rx_baud + 16'd1;
               end
            end
         end
      end
   end

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
   logic [23:0] r_to_cnt;
   always_ff @(posedge clk) begin
      if (!rstn || !is_collect(r_st) || w_rx_start)
         r_to_cnt <= 24'd0;
      else if (!r_rx_busy && r_to_cnt != TIMEOUT_CYC)
         r_to_cnt <= r_to_cnt + 24'd1;
   end
   assign w_timeout = (r_to_cnt == TIMEOUT_CYC);
`else
   logic w_unused_to;
   assign w_unused_to = ^TIMEOUT_CYC;
   assign w_timeout   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) r_st <= ST_IDLE;
      else       r_st <= w_st_nxt;
   end

   always_comb begin
      w_st_nxt = r_st;
      case (r_st)
         ST_IDLE:     if (w_rx_vld && (r_rx_shift == OP_WR || r_rx_shift == OP_RD)) w_st_nxt = ST_ADDR_H;
         ST_ADDR_H:   if (w_rx_vld) w_st_nxt = ST_ADDR_L;
         ST_ADDR_L:   if (w_rx_vld) w_st_nxt = r_wr ? ST_DATA_H : ST_BUS_REQ;
         ST_DATA_H:   if (w_rx_vld) w_st_nxt = ST_DATA_L;
         ST_DATA_L:   if (w_rx_vld) w_st_nxt = ST_BUS_REQ;
         ST_BUS_REQ:  if (busGnt) w_st_nxt = ST_BUS_XFER;
         ST_BUS_XFER: w_st_nxt = ST_RESP;
         ST_RESP:     if ((w_tx_done && (r_wr || r_resp_lo)) || !w_tx_busy) w_st_nxt = ST_IDLE;
         default:     w_st_nxt = ST_IDLE;
      endcase
      // A bad byte or stalled host only abandons a frame still being collected, never a granted transfer.
      if ((w_rx_ferr || w_timeout) && is_collect(r_st))
         w_st_nxt = ST_IDLE;
   end

   always_comb begin
      busReq     = (r_st == ST_BUS_REQ) || (r_st == ST_BUS_XFER);
      busEn      = (r_st == ST_BUS_XFER);
      busWr      = (r_st == ST_BUS_XFER) && r_wr;
      busAddr    = r_addr;
      w_drv_data = (r_st == ST_BUS_XFER) && r_wr;
      w_tx_ld    = 1'b0;
      w_tx_byte  = r_data[7:0];
      if (r_st == ST_BUS_XFER) begin
         w_tx_ld   = 1'b1;
         w_tx_byte = r_wr ? ACK : busData[15:8];
      end else if (r_st == ST_RESP && w_tx_done && !r_wr && !r_resp_lo) begin
         w_tx_ld = 1'b1;
      end
   end

   assign busData = w_drv_data ? r_data : 16'bz;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wr      <= 1'b0;
         r_resp_lo <= 1'b0;
         r_addr    <= 16'd0;
         r_data    <= 16'd0;
      end else begin
         if (w_rx_vld) begin
            case (r_st)
               ST_IDLE:   r_wr          <= (r_rx_shift == OP_WR);
               ST_ADDR_H: r_addr[15:8]  <= r_rx_shift;
               ST_ADDR_L: r_addr[7:0]   <= r_rx_shift;
               ST_DATA_H: r_data[15:8]  <= r_rx_shift;
               ST_DATA_L: r_data[7:0]   <= r_rx_shift;
               default:   ;
            endcase
         end
         if (r_st == ST_BUS_XFER) begin
            r_resp_lo <= 1'b0;
            if (!r_wr) r_data <= busData;
         end else if (r_st == ST_RESP && w_tx_done) begin
            r_resp_lo <= 1'b1;
         end
      end
   end

   uart_bridge_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
      .i_clk  (clk),
      .i_rstn (rstn),
      .i_ld   (w_tx_ld),
      .i_byte (w_tx_byte),
      .o_tx   (txOut),
      .o_busy (w_tx_busy),
      .o_done (w_tx_done)
   );

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge at BAUD_DIV = 8: write/read frames, grant stall, line noise, reset, timeout.
module tb_uart_bus_bridge;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        rxIn = 1'b1;
   logic        busGnt = 1'b1;
   logic        txOut, busReq, busEn, busWr;
   logic [15:0] busAddr;
   wire  [15:0] bus_data;
   logic [15:0] rd_val = 16'h0000;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int          en_cnt = 0;
   int          en_cyc = 0;
   logic        en_wr;
   logic [15:0] en_addr, en_dat;
   int          req_cyc = 0;
   logic        req_prev = 1'b0;
   logic [7:0]  rx_q[$];
   int          rx_t[$];

   uart_bus_bridge #(.BAUD_DIV(16'd8), .TIMEOUT_CYC(24'd200)) dut (
      .clk(clk), .rstn(rstn), .rxIn(rxIn), .txOut(txOut), .busReq(busReq), .busGnt(busGnt),
      .busEn(busEn), .busWr(busWr), .busAddr(busAddr), .busData(bus_data)
   );

   assign bus_data = (busEn === 1'b1 && busWr === 1'b0) ? rd_val : 16'bz;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (busEn === 1'b1) begin
         en_cnt++;
         en_cyc  = cyc;
         en_wr   = busWr;
         en_addr = busAddr;
         en_dat  = bus_data;
      end
      if (busReq === 1'b1 && req_prev !== 1'b1) req_cyc = cyc;
      req_prev = busReq;
   end

   // Serial decoder for txOut: mid-bit sampling, records each byte and its start cycle.
   always begin
      logic [7:0] b;
      int t0;
      @(negedge clk);
      if (rstn === 1'b1 && txOut === 1'b0) begin
         t0 = cyc;
         repeat (4) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (8) @(negedge clk);
            b[i] = txOut;
         end
         repeat (8) @(negedge clk);
         rx_q.push_back(b);
         rx_t.push_back(t0);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      rxIn = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxIn = b[i];
         repeat (8) @(negedge clk);
      end
      rxIn = stop_bit;
      repeat (8) @(negedge clk);
      rxIn = 1'b1;
   endtask

   task automatic wait_rx(input int n, input string tag);
      int k = 0;
      while (rx_q.size() < n && k < 600) begin
         @(negedge clk);
         k++;
      end
      chk(tag, rx_q.size(), n);
   endtask

   task automatic clear_rx();
      rx_q.delete();
      rx_t.delete();
   endtask

   initial begin
      int base, g, low;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_txOut", txOut, 1'b1);
      chk("rst_busReq", busReq, 1'b0);
      chk("rst_busEn", busEn, 1'b0);
      chk("rst_busWr", busWr, 1'b0);
      chk("rst_busAddr", busAddr, 16'h0000);
      rstn = 1'b1;
      repeat (5) @(negedge clk);

      // Write 0xABCD to 0x1234
      base = en_cnt;
      send_byte(8'h57, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
      send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
      wait_rx(1, "wr_resp_cnt");
      chk("wr_en_cnt", en_cnt - base, 1);
      chk("wr_busWr", en_wr, 1'b1);
      chk("wr_addr", en_addr, 16'h1234);
      chk("wr_data", en_dat, 16'hABCD);
      chk("wr_req_to_en", en_cyc - req_cyc, 1);
      chk("wr_ack", rx_q[0], 8'h4B);
      chk("wr_en_to_tx", rx_t[0] - en_cyc, 1);
      repeat (20) @(negedge clk);
      chk("wr_req_drop", busReq, 1'b0);
      clear_rx();

      // Read 0x0002 returning 0x5A5A, two bytes back to back
      rd_val = 16'h5A5A;
      base = en_cnt;
      send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
      wait_rx(2, "rd1_resp_cnt");
      chk("rd1_en_cnt", en_cnt - base, 1);
      chk("rd1_busWr", en_wr, 1'b0);
      chk("rd1_addr", en_addr, 16'h0002);
      chk("rd1_hi", rx_q[0], 8'h5A);
      chk("rd1_lo", rx_q[1], 8'h5A);
      chk("rd1_gap", rx_t[1] - rx_t[0], 80);
      chk("rd1_len", rx_t[1] + 80 - rx_t[0], 160);
      clear_rx();
      repeat (20) @(negedge clk);

      // Read with distinct bytes to pin down byte order
      rd_val = 16'hC381;
      send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'hFF, 1'b1);
      wait_rx(2, "rd2_resp_cnt");
      chk("rd2_addr", en_addr, 16'h00FF);
      chk("rd2_hi", rx_q[0], 8'hC3);
      chk("rd2_lo", rx_q[1], 8'h81);
      clear_rx();
      repeat (20) @(negedge clk);

      // Grant held low for 50 cycles
      busGnt = 1'b0;
      rd_val = 16'h0F0F;
      base = en_cnt;
      send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h04, 1'b1);
      low = 0;
      repeat (50) begin
         @(negedge clk);
         if (busReq !== 1'b1) low++;
      end
      chk("gnt_req_low_cycles", low, 0);
      chk("gnt_no_en", en_cnt - base, 0);
      busGnt = 1'b1;
      g = cyc;
      repeat (10) begin
         if (en_cnt == base) @(negedge clk);
      end
      chk("gnt_en_cnt", en_cnt - base, 1);
      chk("gnt_to_en", en_cyc - g, 1);
      chk("gnt_addr", en_addr, 16'h0004);
      wait_rx(2, "gnt_resp_cnt");
      chk("gnt_hi", rx_q[0], 8'h0F);
      clear_rx();
      repeat (20) @(negedge clk);

      // Junk byte, short glitch, 'W' with bad stop bit: all ignored
      base = en_cnt;
      send_byte(8'h00, 1'b1);
      repeat (10) @(negedge clk);
      rxIn = 1'b0;
      repeat (3) @(negedge clk);
      rxIn = 1'b1;
      repeat (20) @(negedge clk);
      send_byte(8'h57, 1'b0);
      repeat (150) @(negedge clk);
      chk("noise_no_en", en_cnt - base, 0);
      chk("noise_no_resp", rx_q.size(), 0);
      send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
      send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
      wait_rx(1, "noise_wr_resp_cnt");
      chk("noise_wr_addr", en_addr, 16'h0010);
      chk("noise_wr_data", en_dat, 16'h1234);
      chk("noise_wr_ack", rx_q[0], 8'h4B);
      clear_rx();
      repeat (20) @(negedge clk);

      // Reset in the middle of a read response
      rd_val = 16'h0000;
      send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h08, 1'b1);
      low = 0;
      while (txOut !== 1'b0 && low < 300) begin
         @(negedge clk);
         low++;
      end
      chk("rst_mid_tx_started", txOut, 1'b0);
      repeat (20) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      chk("rst_mid_txOut", txOut, 1'b1);
      chk("rst_mid_busReq", busReq, 1'b0);
      rstn = 1'b1;
      repeat (120) @(negedge clk);
      clear_rx();
      send_byte(8'h57, 1'b1); send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
      send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
      wait_rx(1, "post_rst_resp_cnt");
      chk("post_rst_addr", en_addr, 16'hABCD);
      chk("post_rst_data", en_dat, 16'h0001);
      chk("post_rst_ack", rx_q[0], 8'h4B);
      clear_rx();
      repeat (20) @(negedge clk);

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
      // Partial write frame abandoned after the idle timeout
      rd_val = 16'h1357;
      send_byte(8'h57, 1'b1); send_byte(8'h12, 1'b1);
      repeat (250) @(negedge clk);
      send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
      wait_rx(2, "to_resp_cnt");
      chk("to_busWr", en_wr, 1'b0);
      chk("to_addr", en_addr, 16'h0000);
      chk("to_hi", rx_q[0], 8'h13);
      chk("to_lo", rx_q[1], 8'h57);
      clear_rx();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
